// File: rtl/mdio_master.sv
// Clause-22 MDIO/MDC master: serialises one register read or write frame per
// request, releases the bus for read turnaround and returns the sampled data.
module mdio_master #(
    parameter int CLK_DIV     = 25,
    parameter bit PREAMBLE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_phy_addr,
    input  logic [4:0]  req_reg_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic        mdio_i
);

    localparam int N     = PREAMBLE_EN ? 64 : 32;
    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int BIT_W = 6;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [N-1:0]      frame_sh;
    logic [63:0]       frame_full;
    logic [15:0]       rd_sh;
    logic              is_read;
    logic              ta_err;
    logic              accept;
    logic              mid_bit;
    logic              end_bit;
    logic              last_bit;

    // Read frames carry ones in TA/DATA so the idle level sits on mdio_o while released.
    function automatic logic [63:0] build_frame(input logic wr, input logic [4:0] phy,
                                                input logic [4:0] reg_a, input logic [15:0] wd);
        build_frame = {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), phy, reg_a,
                       (wr ? 2'b10 : 2'b11), (wr ? wd : 16'hFFFF)};
    endfunction

    assign frame_full = build_frame(req_write, req_phy_addr, req_reg_addr, req_wdata);
    assign accept     = (state == IDLE) && req_valid;
    assign mid_bit    = (state == SHIFT) && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign end_bit    = (state == SHIFT) && (div_cnt == DIV_W'(2 * CLK_DIV - 1));
    assign last_bit   = end_bit && (bit_cnt == BIT_W'(N - 1));
    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = SHIFT;
            SHIFT:   if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus timing: bits launch on mdc falling edges, mdio_i is sampled on rising edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            mdc       <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_t    <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 16'h0000;
            is_read   <= 1'b0;
            ta_err    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                div_cnt <= '0;
                bit_cnt <= '0;
                is_read <= ~req_write;
                ta_err  <= 1'b0;
                mdio_o  <= frame_full[N-1];
                mdio_t  <= 1'b0;
            end else if (state == SHIFT) begin
                if (end_bit) begin
                    div_cnt <= '0;
                    mdc     <= 1'b0;
                    if (last_bit) begin
                        bit_cnt   <= '0;
                        mdio_o    <= 1'b1;
                        mdio_t    <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= is_read & ta_err;
                        if (is_read) rsp_rdata <= rd_sh;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        mdio_o  <= frame_sh[N-2];
                        mdio_t  <= is_read && (bit_cnt >= BIT_W'(N - 19));
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                    if (mid_bit) begin
                        mdc <= 1'b1;
                        if (bit_cnt == BIT_W'(N - 17)) ta_err <= mdio_i;
                    end
                end
            end
        end
    end

    // The last 16 mid-bit samples of a frame are the read data.
    always_ff @(posedge clk) begin
        if (accept)       frame_sh <= frame_full[N-1:0];
        else if (end_bit) frame_sh <= {frame_sh[N-2:0], 1'b1};
        if (mid_bit)      rd_sh    <= {rd_sh[14:0], mdio_i};
    end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: two configurations (div 4 with preamble,
// div 2 without) share stimulus; sel picks which one is driven and observed.
module tb_mdio_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [4:0]  req_phy_addr;
    logic [4:0]  req_reg_addr;
    logic [15:0] req_wdata;
    logic        mdio_i;
    logic        sel;

    logic        a_ready, a_rsp_valid, a_rsp_err, a_busy, a_mdc, a_mdio_o, a_mdio_t;
    logic [15:0] a_rdata;
    logic        b_ready, b_rsp_valid, b_rsp_err, b_busy, b_mdc, b_mdio_o, b_mdio_t;
    logic [15:0] b_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdio_master #(.CLK_DIV(4), .PREAMBLE_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(a_ready),
        .req_write(req_write), .req_phy_addr(req_phy_addr), .req_reg_addr(req_reg_addr),
        .req_wdata(req_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata),
        .rsp_err(a_rsp_err), .busy(a_busy), .mdc(a_mdc), .mdio_o(a_mdio_o),
        .mdio_t(a_mdio_t), .mdio_i(mdio_i)
    );

    mdio_master #(.CLK_DIV(2), .PREAMBLE_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(b_ready),
        .req_write(req_write), .req_phy_addr(req_phy_addr), .req_reg_addr(req_reg_addr),
        .req_wdata(req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata),
        .rsp_err(b_rsp_err), .busy(b_busy), .mdc(b_mdc), .mdio_o(b_mdio_o),
        .mdio_t(b_mdio_t), .mdio_i(mdio_i)
    );

    wire        ready_s = sel ? b_ready     : a_ready;
    wire        rspv_s  = sel ? b_rsp_valid : a_rsp_valid;
    wire        err_s   = sel ? b_rsp_err   : a_rsp_err;
    wire        busy_s  = sel ? b_busy      : a_busy;
    wire        mdc_s   = sel ? b_mdc       : a_mdc;
    wire        mo_s    = sel ? b_mdio_o    : a_mdio_o;
    wire        mt_s    = sel ? b_mdio_t    : a_mdio_t;
    wire [15:0] rdata_s = sel ? b_rdata     : a_rdata;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_checks(input string tag, input logic [15:0] exp_rdata, input logic exp_err);
        chk({tag, " ready"}, ready_s, 1);
        chk({tag, " busy"}, busy_s, 0);
        chk({tag, " rsp_valid"}, rspv_s, 0);
        chk({tag, " rsp_err"}, err_s, exp_err);
        chk({tag, " rdata"}, rdata_s, exp_rdata);
        chk({tag, " mdc"}, mdc_s, 0);
        chk({tag, " mdio_t"}, mt_s, 1);
        chk({tag, " mdio_o"}, mo_s, 1);
    endtask

    // Called in the accept cycle T0; returns in cycle T0+2+2ND (or after an abort).
    // exp_bits holds frame bit k at position 63-k.
    task automatic run_frame(input string tag, input int d, input int n, input logic wr,
                             input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd,
                             input logic [63:0] exp_bits, input logic ta2, input logic [15:0] pdata,
                             input logic [15:0] exp_rdata, input logic exp_err,
                             input bit hold, input int abort_k);
        int  k, ph;
        bit  driven, seen;
        logic exp_t;
        chk({tag, " ready@T0"}, ready_s, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_phy_addr = phy;
        req_reg_addr = rg;
        req_wdata = wd;
        for (int c = 1; c <= 2 * n * d; c++) begin
            cyc();
            k  = (c - 1) / (2 * d);
            ph = (c - 1) % (2 * d);
            if (!hold) req_valid = 1'b0;
            else if (k == n - 28 && ph == 0) req_phy_addr = phy ^ 5'h1F;
            else req_phy_addr = phy;
            if (k == abort_k && ph == 0) begin
                rst = 1'b1;
                cyc();
                rst = 1'b0;
                chk({tag, " abort mdc"}, mdc_s, 0);
                chk({tag, " abort mdio_t"}, mt_s, 1);
                chk({tag, " abort mdio_o"}, mo_s, 1);
                chk({tag, " abort busy"}, busy_s, 0);
                chk({tag, " abort rsp_valid"}, rspv_s, 0);
                chk({tag, " abort ready"}, ready_s, 1);
                seen = 1'b0;
                for (int i = 0; i < 2 * n * d; i++) begin
                    cyc();
                    if (rspv_s || busy_s) seen = 1'b1;
                end
                chk({tag, " abort no rsp"}, seen, 0);
                return;
            end
            if (!wr && k == n - 17)     mdio_i = ta2;
            else if (!wr && k >= n - 16) mdio_i = pdata[n - 1 - k];
            else                         mdio_i = 1'b1;
            driven = wr || (k < n - 18);
            exp_t  = !driven;
            if (ph == 0) begin
                chk($sformatf("%s bit%0d mdc0", tag, k), mdc_s, 0);
                chk($sformatf("%s bit%0d mdio_t", tag, k), mt_s, exp_t);
                if (driven) chk($sformatf("%s bit%0d mdio_o", tag, k), mo_s, exp_bits[63 - k]);
                chk($sformatf("%s bit%0d busy", tag, k), busy_s, 1);
                chk($sformatf("%s bit%0d rsp_valid", tag, k), rspv_s, 0);
            end
            if (ph == d) begin
                chk($sformatf("%s bit%0d mdc1", tag, k), mdc_s, 1);
                chk($sformatf("%s bit%0d mdio_t hold", tag, k), mt_s, exp_t);
            end
            if (ph == 2 * d - 1 && driven)
                chk($sformatf("%s bit%0d mdio_o hold", tag, k), mo_s, exp_bits[63 - k]);
        end
        cyc();
        mdio_i = 1'b1;
        chk({tag, " done rsp_valid"}, rspv_s, 1);
        chk({tag, " done mdc"}, mdc_s, 0);
        chk({tag, " done mdio_t"}, mt_s, 1);
        chk({tag, " done rdata"}, rdata_s, exp_rdata);
        chk({tag, " done rsp_err"}, err_s, exp_err);
        chk({tag, " done ready"}, ready_s, 0);
        cyc();
        chk({tag, " idle rsp_valid"}, rspv_s, 0);
        chk({tag, " idle ready"}, ready_s, 1);
        chk({tag, " idle busy"}, busy_s, 0);
        chk({tag, " idle mdio_t"}, mt_s, 1);
        chk({tag, " idle mdio_o"}, mo_s, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_phy_addr = 5'd0;
        req_reg_addr = 5'd0;
        req_wdata = 16'h0000;
        mdio_i = 1'b1;
        sel = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        idle_checks("reset a", 16'h0000, 1'b0);
        sel = 1'b1;
        #0;
        idle_checks("reset b", 16'h0000, 1'b0);
        sel = 1'b0;
        cyc();

        run_frame("rd phy1 reg2", 4, 64, 1'b0, 5'd1, 5'd2, 16'h0000,
                  {32'hFFFF_FFFF, 4'b0110, 5'b00001, 5'b00010, 18'h3FFFF},
                  1'b0, 16'h0141, 16'h0141, 1'b0, 1'b0, -1);
        cyc();
        run_frame("wr phy0 reg0", 4, 64, 1'b1, 5'd0, 5'd0, 16'h1140,
                  {32'hFFFF_FFFF, 4'b0101, 5'b00000, 5'b00000, 2'b10, 16'b0001000101000000},
                  1'b1, 16'hFFFF, 16'h0141, 1'b0, 1'b0, -1);
        cyc();
        run_frame("rd no phy", 4, 64, 1'b0, 5'd3, 5'd1, 16'h0000,
                  {32'hFFFF_FFFF, 4'b0110, 5'b00011, 5'b00001, 18'h3FFFF},
                  1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, -1);
        cyc();
        run_frame("wr held", 4, 64, 1'b1, 5'd4, 5'd9, 16'hBEEF,
                  {32'hFFFF_FFFF, 4'b0101, 5'b00100, 5'b01001, 2'b10, 16'hBEEF},
                  1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, -1);
        run_frame("wr held 2nd", 4, 64, 1'b1, 5'd4, 5'd9, 16'hBEEF,
                  {32'hFFFF_FFFF, 4'b0101, 5'b00100, 5'b01001, 2'b10, 16'hBEEF},
                  1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, -1);
        cyc();
        run_frame("wr abort", 4, 64, 1'b1, 5'd7, 5'd4, 16'h1234,
                  {32'hFFFF_FFFF, 4'b0101, 5'b00111, 5'b00100, 2'b10, 16'h1234},
                  1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 40);
        idle_checks("after abort", 16'h0000, 1'b0);
        cyc();
        run_frame("rd after abort", 4, 64, 1'b0, 5'd1, 5'd3, 16'h0000,
                  {32'hFFFF_FFFF, 4'b0110, 5'b00001, 5'b00011, 18'h3FFFF},
                  1'b0, 16'hA5C3, 16'hA5C3, 1'b0, 1'b0, -1);
        cyc();

        // Reset wins over a simultaneous request.
        rst = 1'b1;
        req_valid = 1'b1;
        cyc();
        rst = 1'b0;
        req_valid = 1'b0;
        chk("rst vs req busy", busy_s, 0);
        chk("rst vs req ready", ready_s, 1);
        cyc();
        chk("rst vs req busy later", busy_s, 0);
        chk("rst vs req mdc", mdc_s, 0);

        sel = 1'b1;
        cyc();
        run_frame("b rd nopre", 2, 32, 1'b0, 5'd2, 5'd1, 16'h0000,
                  {4'b0110, 5'b00010, 5'b00001, 50'h3_FFFF_FFFF_FFFF},
                  1'b0, 16'h7960, 16'h7960, 1'b0, 1'b0, -1);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
